// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU operation scheduler.
package alu_sched_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } sched_state_t;

  // Unit group carried in the top two bits of the ALU operation code
  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_CMP   = 2'b10;
  localparam logic [1:0] GRP_SHIFT = 2'b11;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last-grant pointer.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       update_en,
  output logic [1:0] grant
);

  logic last_grant;

  // Under contention the requester that did not win last time goes first
  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (update_en)
      last_grant <= grant[1];
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between two requesters: round-robin grant, one-cycle issue, wait for result, respond.
// Optional WAIT timeout with error response is enabled by defining ALU_SCHED_TIMEOUT_EN.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_REQ-1:0]      REQ_VALID,
  output logic [NUM_REQ-1:0]      REQ_READY,
  input  logic [2*FUN_WIDTH-1:0]  REQ_FUN,
  input  logic [2*DATA_WIDTH-1:0] REQ_A,
  input  logic [2*DATA_WIDTH-1:0] REQ_B,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic [NUM_REQ-1:0]      RSP_VALID,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_ERR,
  output logic                    BUSY
);

  sched_state_t state, next_state;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [NUM_REQ-1:0]    owner;
  logic                  grant_fire;
  logic                  timed_out;
  logic [FUN_WIDTH-1:0]  sel_fun;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;

  assign grant_fire = (state == IDLE) && (|REQ_VALID);

  rr_arbiter_2 u_arb (
    .clk       (CLK),
    .rst       (RST),
    .valid     (REQ_VALID),
    .update_en (grant_fire && (&REQ_VALID)),
    .grant     (arb_grant)
  );

  assign sel_fun = arb_grant[1] ? REQ_FUN[FUN_WIDTH +: FUN_WIDTH]   : REQ_FUN[0 +: FUN_WIDTH];
  assign sel_a   = arb_grant[1] ? REQ_A[DATA_WIDTH +: DATA_WIDTH]   : REQ_A[0 +: DATA_WIDTH];
  assign sel_b   = arb_grant[1] ? REQ_B[DATA_WIDTH +: DATA_WIDTH]   : REQ_B[0 +: DATA_WIDTH];

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Cleared while issuing so the count starts from zero on the first WAIT cycle
  always_ff @(posedge CLK) begin
    if (RST || state == ISSUE)
      wait_cnt <= '0;
    else if (state == WAIT && !ALU_OUT_VALID)
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = (state == WAIT) && !ALU_OUT_VALID &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (|REQ_VALID) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (ALU_OUT_VALID || timed_out) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The grant is suppressed while reset is asserted since nothing is captured that cycle
  always_comb begin
    REQ_READY = '0;
    if (state == IDLE && !RST)
      REQ_READY = arb_grant;
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_EN    <= 1'b0;
      ALU_FUN   <= '0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      owner     <= '0;
      RSP_VALID <= '0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      ALU_EN    <= grant_fire;
      RSP_VALID <= '0;
      RSP_ERR   <= 1'b0;
      if (grant_fire) begin
        owner   <= arb_grant;
        ALU_FUN <= sel_fun;
        ALU_A   <= sel_a;
        ALU_B   <= sel_b;
      end
      if (state == WAIT) begin
        if (ALU_OUT_VALID) begin
          RSP_DATA  <= ALU_OUT;
          RSP_VALID <= owner;
        end else if (timed_out) begin
          RSP_DATA  <= '0;
          RSP_VALID <= owner;
          RSP_ERR   <= 1'b1;
        end
      end
    end
  end

endmodule
